// File: rtl/peripheral_seg7_scan_if.sv
// Frame-write handshake between a digit decoder and the 7-segment scanner.
// The master offers a full frame of active-low gfedcba patterns; the slave raises ready when free.
interface peripheral_seg7_scan_if #(
  parameter int unsigned N_DIGITS = 4
) ();
  logic                  wr_valid;
  logic                  wr_ready;
  logic [7*N_DIGITS-1:0] wr_frame;

  modport master (
    output wr_valid,
    output wr_frame,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_frame,
    output wr_ready
  );
endinterface

// File: rtl/peripheral_seg7_scan.sv
// Multiplexed 7-segment scanner with a double-buffered frame and a per-slot dead-time guard.
// A written frame waits in the shadow buffer until the next frame boundary, so a scan never tears.
module peripheral_seg7_scan #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD_CYC   = 500
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  peripheral_seg7_scan_if.slave       wr,
  input  logic [N_DIGITS-1:0]         blank_mask,
  output logic [6:0]                  SEG,
  output logic [N_DIGITS-1:0]         AN,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_sync
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = $clog2(N_DIGITS);

  typedef enum logic {StGuard, StDrive} slot_e;

  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [N_DIGITS-1:0][6:0]     shadow_q, shadow_d;
  logic [N_DIGITS-1:0][6:0]     active_q, active_d;
  logic                         pending_q, pending_d;
  logic                         en_q, en_d;
  logic [6:0]                   seg_q, seg_d;
  logic [N_DIGITS-1:0]          an_q, an_d;
  logic                         sync_q, sync_d;

  slot_e slot;
  logic  slot_last;
  logic  wrap;
  logic  boundary;

  assign slot      = (cnt_q < CntW'(GUARD_CYC)) ? StGuard : StDrive;
  assign slot_last = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign wrap      = slot_last && (idx_q == IdxW'(N_DIGITS - 1));
  // A boundary is either the wrap back to digit 0 or the first enabled cycle after a dark period.
  assign boundary  = enable && (!en_q || wrap);

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    en_d      = enable;
    seg_d     = 7'h7F;
    an_d      = '1;
    sync_d    = 1'b0;

    // Acceptance needs pending clear and commit needs it set, so both can never hit in one cycle.
    if (wr.wr_valid && !pending_q) begin
      shadow_d  = wr.wr_frame;
      pending_d = 1'b1;
    end

    if (boundary) begin
      sync_d = 1'b1;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    if (enable) begin
      if (slot_last) begin
        cnt_d = '0;
        idx_d = (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end

      if (slot == StDrive) begin
        an_d[idx_q] = 1'b0;
        seg_d       = blank_mask[idx_q] ? 7'h7F : active_q[idx_q];
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '1;
      active_q  <= '1;
      pending_q <= 1'b0;
      en_q      <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= '1;
      sync_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      sync_q    <= sync_d;
    end
  end

  assign wr.wr_ready = ~pending_q;
  assign SEG         = seg_q;
  assign AN          = an_q;
  assign digit_idx   = idx_q;
  assign frame_sync  = sync_q;

endmodule
